// File: rtl/pzbcm_arbiter_requester.sv
// Requester-side agent for one port of a KEEP_RESULT, one-hot pzbcm_arbiter.
// Buffers upstream packets, requests the port, forwards beats under grant and frees on tenure end.
module pzbcm_arbiter_requester #(
    parameter int DATA_WIDTH   = 32,
    parameter int MAX_BEATS    = 0,
    parameter int STARVE_LIMIT = 256,
    parameter int WAIT_WIDTH   = $clog2(STARVE_LIMIT + 1)
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_valid,
    output logic                  o_ready,
    input  logic [DATA_WIDTH-1:0] i_data,
    input  logic                  i_last,
    output logic                  o_request,
    input  logic                  i_grant,
    output logic                  o_free,
    output logic                  o_valid,
    input  logic                  i_ready,
    output logic [DATA_WIDTH-1:0] o_data,
    output logic                  o_last,
    output logic                  o_starved,
    output logic [WAIT_WIDTH-1:0] o_max_wait
);
    localparam int BEAT_WIDTH = (MAX_BEATS == 0) ? 1 : $clog2(MAX_BEATS + 1);
    localparam logic [BEAT_WIDTH-1:0] LAST_BEAT = BEAT_WIDTH'((MAX_BEATS == 0) ? 0 : MAX_BEATS - 1);
    localparam logic [WAIT_WIDTH-1:0] WAIT_MAX  = WAIT_WIDTH'(STARVE_LIMIT);
    localparam logic                  SPLIT_EN  = (MAX_BEATS != 0);

    localparam logic [0:0] IDLE     = 1'b0;
    localparam logic [0:0] TRANSFER = 1'b1;

    logic [DATA_WIDTH:0]   r_mem [2];
    logic                  r_wr_ptr;
    logic                  r_rd_ptr;
    logic [1:0]            r_count;
    logic [1:0]            w_count_nxt;
    logic                  r_ready;
    logic                  w_push;
    logic                  w_pop;
    logic                  w_nonempty;
    logic [0:0]            r_state;
    logic [BEAT_WIDTH-1:0] r_beats;
    logic                  w_tenure_end;
    logic [WAIT_WIDTH-1:0] r_wait;
    logic [WAIT_WIDTH-1:0] r_max_wait;

    assign w_nonempty   = (r_count != 2'd0);
    assign w_push       = i_valid && r_ready;
    assign w_pop        = o_valid && i_ready;
    assign o_ready      = r_ready;
    assign o_request    = (r_state == IDLE) && w_nonempty;
    assign o_valid      = (r_state == TRANSFER) && w_nonempty && i_grant;
    assign {o_last, o_data} = r_mem[r_rd_ptr];
    assign w_tenure_end = w_pop && (o_last || (SPLIT_EN && (r_beats == LAST_BEAT)));
    assign o_free       = w_tenure_end;
    assign o_starved    = (r_wait >= WAIT_MAX);
    assign o_max_wait   = r_max_wait;

    always_comb begin
        w_count_nxt = r_count;
        if (w_push && !w_pop) begin
            w_count_nxt = r_count + 2'd1;
        end else if (!w_push && w_pop) begin
            w_count_nxt = r_count - 2'd1;
        end
    end

    // Ready is registered from the next count so it never depends on i_ready.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_mem[0] <= '0;
            r_mem[1] <= '0;
            r_wr_ptr <= 1'b0;
            r_rd_ptr <= 1'b0;
            r_count  <= '0;
            r_ready  <= 1'b0;
        end else begin
            if (w_push) begin
                r_mem[r_wr_ptr] <= {i_last, i_data};
                r_wr_ptr        <= ~r_wr_ptr;
            end
            if (w_pop) begin
                r_rd_ptr <= ~r_rd_ptr;
            end
            r_count <= w_count_nxt;
            r_ready <= (w_count_nxt != 2'd2);
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= IDLE;
            r_beats <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (o_request && i_grant) begin
                        r_state <= TRANSFER;
                        r_beats <= '0;
                    end
                end
                TRANSFER: begin
                    if (w_tenure_end) begin
                        r_state <= IDLE;
                    end
                    if (w_pop) begin
                        r_beats <= r_beats + 1'b1;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_wait     <= '0;
            r_max_wait <= '0;
        end else if (o_request) begin
            if (i_grant) begin
                if (r_wait > r_max_wait) begin
                    r_max_wait <= r_wait;
                end
                r_wait <= '0;
            end else if (r_wait != WAIT_MAX) begin
                r_wait <= r_wait + 1'b1;
            end
        end
    end
endmodule
